// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares the single SDRAM controller port between three requesters:
//   video fetch (read-only), Z80 CPU and the tape/ioctl loader DMA.
//   Fixed priority video > cpu > loader. The loader has a starvation guard:
//   after STARVE_MAX cpu grants made while the loader waits, the loader wins.
//   Only one transaction is in flight at a time.
//   FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//
//   Optional feature: define ARB_REFRESH_EN to add a periodic refresh request.
//   A refresh pulses mem_rfsh and outranks every requester.
//
// Ports
//   clock, reset                   system clock, synchronous active-high reset
//   vid_req/vid_addr               video read request (level, held until ack)
//   vid_ack/vid_q                  1-cycle done pulse, read data held until next ack
//   cpu_req/cpu_we/cpu_addr/cpu_d  cpu request; cpu_ack/cpu_q response
//   ldr_req/ldr_we/ldr_addr/ldr_d  loader request; ldr_ack/ldr_q response
//   mem_req/mem_we/mem_addr/mem_d  SDRAM controller command (registered)
//   mem_q/mem_ready                SDRAM controller read data / completion pulse
//   mem_rfsh                       1-cycle refresh command pulse
//   busy                           high whenever the FSM is not in IDLE
//   timeout_err                    sticky WAIT-timeout flag, cleared by reset only
module sdram_arbiter #(
    parameter int unsigned AW             = 22,
    parameter int unsigned DW             = 8,
    parameter int unsigned STARVE_MAX     = 4,
    parameter int unsigned TIMEOUT        = 255,
    parameter int unsigned REFRESH_CYCLES = 546
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_q,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_d,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_q,

    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_d,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_q,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q,
    input  logic          mem_ready,
    output logic          mem_rfsh,

    output logic          busy,
    output logic          timeout_err
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_LDR} owner_t;

    state_t        state;
    owner_t        owner;
    logic [SW-1:0] starve_cnt;
    logic [7:0]    wait_cnt;
    logic          ref_pending;
    logic          ldr_starved;

    assign ldr_starved = ldr_req && (starve_cnt == SW'(STARVE_MAX));

`ifdef ARB_REFRESH_EN
    localparam int unsigned RW = $clog2(REFRESH_CYCLES);

    logic [RW-1:0] ref_cnt;

    // Free-running refresh timer. A wrap while a refresh is already pending
    // is absorbed; the grant in IDLE consumes the pending request.
    always_ff @(posedge clock) begin
        if (reset) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            if (ref_cnt == RW'(REFRESH_CYCLES - 1)) begin
                ref_cnt     <= '0;
                ref_pending <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end
            if (state == ST_IDLE && ref_pending)
                ref_pending <= 1'b0;
        end
    end
`else
    assign ref_pending = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= OWN_NONE;
            starve_cnt  <= '0;
            wait_cnt    <= '0;
            vid_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            ldr_ack     <= 1'b0;
            vid_q       <= '0;
            cpu_q       <= '0;
            ldr_q       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_d       <= '0;
            mem_rfsh    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            vid_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            ldr_ack  <= 1'b0;
            mem_req  <= 1'b0;
            mem_rfsh <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (!ldr_req)
                        starve_cnt <= '0;

                    if (ref_pending) begin
                        owner    <= OWN_NONE;
                        mem_rfsh <= 1'b1;
                        mem_we   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end else if (vid_req) begin
                        owner    <= OWN_VID;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= vid_addr;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end else if (ldr_starved || (ldr_req && !cpu_req)) begin
                        owner      <= OWN_LDR;
                        mem_req    <= 1'b1;
                        mem_we     <= ldr_we;
                        mem_addr   <= ldr_addr;
                        mem_d      <= ldr_d;
                        starve_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= ST_ISSUE;
                    end else if (cpu_req) begin
                        owner    <= OWN_CPU;
                        mem_req  <= 1'b1;
                        mem_we   <= cpu_we;
                        mem_addr <= cpu_addr;
                        mem_d    <= cpu_d;
                        if (ldr_req && starve_cnt != SW'(STARVE_MAX))
                            starve_cnt <= starve_cnt + SW'(1);
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    // mem_ready is checked first so it wins over a
                    // timeout expiring on the same cycle.
                    if (mem_ready) begin
                        unique case (owner)
                            OWN_VID: begin vid_q <= mem_q; vid_ack <= 1'b1; end
                            OWN_CPU: begin cpu_q <= mem_q; cpu_ack <= 1'b1; end
                            OWN_LDR: begin ldr_q <= mem_q; ldr_ack <= 1'b1; end
                            default: ;
                        endcase
                        mem_we <= 1'b0;
                        state  <= ST_DONE;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        // wait_cnt counts completed WAIT cycles, so this is
                        // the TIMEOUT-th one. Abandon without ack.
                        timeout_err <= 1'b1;
                        mem_we      <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    localparam int AW = 22;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          vid_req, cpu_req, cpu_we, ldr_req, ldr_we;
    logic [AW-1:0] vid_addr, cpu_addr, ldr_addr;
    logic [DW-1:0] cpu_d, ldr_d;
    logic          vid_ack, cpu_ack, ldr_ack;
    logic [DW-1:0] vid_q, cpu_q, ldr_q;
    logic          mem_req, mem_we, mem_ready, mem_rfsh, busy, timeout_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d, mem_q;

    int total = 0;
    int bad   = 0;
    int rfsh_seen = 0;

    sdram_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(4), .TIMEOUT(255), .REFRESH_CYCLES(546)
    ) dut (
        .clock(clock), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_q(vid_q),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_d(cpu_d),
        .cpu_ack(cpu_ack), .cpu_q(cpu_q),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_d(ldr_d),
        .ldr_ack(ldr_ack), .ldr_q(ldr_q),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_d(mem_d),
        .mem_q(mem_q), .mem_ready(mem_ready), .mem_rfsh(mem_rfsh),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (mem_rfsh === 1'b1) rfsh_seen++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for mem_req, then check the latched command.
    task automatic wait_req(input string tag, input logic [AW-1:0] exp_addr, input logic exp_we);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        check({tag, "_we"}, 32'(mem_we), 32'(exp_we));
    endtask

    // Serve one transaction: mem_ready after lat extra WAIT cycles. Returns in DONE.
    task automatic serve(input string tag, input logic [AW-1:0] exp_addr, input logic exp_we,
                         input int lat, input logic [DW-1:0] q);
        wait_req(tag, exp_addr, exp_we);
        tick();
        repeat (lat) tick();
        mem_q     = q;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        vid_req = 0; cpu_req = 0; cpu_we = 0; ldr_req = 0; ldr_we = 0;
        vid_addr = 22'h000100; cpu_addr = 22'h000200; ldr_addr = 22'h000300;
        cpu_d = '0; ldr_d = '0; mem_q = '0; mem_ready = 0;
        tick(); tick();

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        reset = 1'b0;
        tick();

        // 1: reset mid-WAIT, late mem_ready ignored
        cpu_req = 1; cpu_we = 0; cpu_addr = 22'h000123;
        tick(); tick(); tick();
        check("t1_busy_before", 32'(busy), 1);
        reset = 1; cpu_req = 0;
        tick();
        check("t1_busy", 32'(busy), 0);
        check("t1_acks", {29'd0, vid_ack, cpu_ack, ldr_ack}, 0);
        check("t1_mem", {29'd0, mem_req, mem_we, mem_rfsh}, 0);
        check("t1_addr_d", {2'b0, mem_addr, mem_d}, 0);
        check("t1_qs", {8'd0, vid_q, cpu_q, ldr_q}, 0);
        reset = 0;
        tick(); tick();
        mem_q = 8'h99; mem_ready = 1;
        tick();
        mem_ready = 0;
        check("t1_no_ack", 32'(cpu_ack), 0);
        tick();
        check("t1_no_ack2", 32'(cpu_ack), 0);
        check("t1_idle", 32'(busy), 0);
        check("t1_cpu_q", 32'(cpu_q), 0);

        // 2: cpu write, exact latency
        cpu_req = 1; cpu_we = 1; cpu_addr = 22'h003C00; cpu_d = 8'h41;
        tick();                                          // cycle 1
        check("t2_mem_req", 32'(mem_req), 1);
        check("t2_mem_we", 32'(mem_we), 1);
        check("t2_mem_addr", 32'(mem_addr), 32'h003C00);
        check("t2_mem_d", 32'(mem_d), 32'h41);
        tick();                                          // cycle 2
        check("t2_req_pulse", 32'(mem_req), 0);
        check("t2_we_held", 32'(mem_we), 1);
        tick();                                          // cycle 3
        tick();                                          // cycle 4
        mem_q = 8'h00; mem_ready = 1;
        check("t2_ack_early", 32'(cpu_ack), 0);
        tick();                                          // cycle 5
        mem_ready = 0;
        check("t2_ack", 32'(cpu_ack), 1);
        cpu_req = 0; cpu_we = 0;
        tick();
        check("t2_ack_pulse", 32'(cpu_ack), 0);
        check("t2_idle", 32'(busy), 0);

        // 3: simultaneous requests, priority vid > cpu > ldr; video never writes
        cpu_addr = 22'h000200;
        vid_req = 1; cpu_req = 1; ldr_req = 1; cpu_we = 1; ldr_we = 0;
        serve("t3_vid", 22'h000100, 1'b0, 1, 8'h55);
        check("t3_vid_ack", {29'd0, vid_ack, cpu_ack, ldr_ack}, 32'b100);
        check("t3_vid_q", 32'(vid_q), 32'h55);
        vid_req = 0; cpu_we = 0;
        tick();
        serve("t3_cpu", 22'h000200, 1'b0, 0, 8'h66);
        check("t3_cpu_ack", {29'd0, vid_ack, cpu_ack, ldr_ack}, 32'b010);
        check("t3_cpu_q", 32'(cpu_q), 32'h66);
        cpu_req = 0;
        tick();
        serve("t3_ldr", 22'h000300, 1'b0, 2, 8'h77);
        check("t3_ldr_ack", {29'd0, vid_ack, cpu_ack, ldr_ack}, 32'b001);
        check("t3_ldr_q", 32'(ldr_q), 32'h77);
        check("t3_vid_q_held", 32'(vid_q), 32'h55);
        ldr_req = 0;
        tick();

        // 4: cpu and loader held: C C C C L, repeated
        cpu_req = 1; ldr_req = 1;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                serve("t4_ldr", 22'h000300, 1'b0, 0, 8'(k));
                check("t4_ldr_ack", 32'(ldr_ack), 1);
            end else begin
                serve("t4_cpu", 22'h000200, 1'b0, 0, 8'(k));
                check("t4_cpu_ack", 32'(cpu_ack), 1);
            end
            tick();
        end
        cpu_req = 0; ldr_req = 0;
        tick(); tick();

        // 5a: mem_ready on the last allowed WAIT cycle wins over timeout
        cpu_req = 1;
        serve("t5a", 22'h000200, 1'b0, 254, 8'hC3);
        check("t5a_ack", 32'(cpu_ack), 1);
        check("t5a_q", 32'(cpu_q), 32'hC3);
        check("t5a_no_err", 32'(timeout_err), 0);
        cpu_req = 0;
        tick(); tick();

        // 5b: no mem_ready -> back to IDLE after 255 WAIT cycles
        cpu_req = 1;
        wait_req("t5b", 22'h000200, 1'b0);
        tick();
        repeat (254) tick();
        check("t5b_still_wait", 32'(busy), 1);
        check("t5b_err_early", 32'(timeout_err), 0);
        tick();
        check("t5b_idle", 32'(busy), 0);
        check("t5b_err", 32'(timeout_err), 1);
        check("t5b_no_ack", 32'(cpu_ack), 0);
        tick();
        serve("t5b_retry", 22'h000200, 1'b0, 1, 8'h3C);
        check("t5b_retry_ack", 32'(cpu_ack), 1);
        check("t5b_retry_q", 32'(cpu_q), 32'h3C);
        check("t5b_sticky", 32'(timeout_err), 1);
        cpu_req = 0;
        tick();

        // 7: loader write, req dropped early still completes
        ldr_req = 1; ldr_we = 1; ldr_addr = 22'h2AAAAA; ldr_d = 8'hA5;
        wait_req("t7", 22'h2AAAAA, 1'b1);
        check("t7_d", 32'(mem_d), 32'hA5);
        ldr_req = 0; ldr_we = 0;
        tick(); tick();
        mem_ready = 1;
        tick();
        mem_ready = 0;
        check("t7_ack", 32'(ldr_ack), 1);
        tick();
        check("t7_idle", 32'(busy), 0);
        check("t7_ack_pulse", 32'(ldr_ack), 0);

`ifdef ARB_REFRESH_EN
        // 6: refresh pulses with cpu_req held, no cpu_ack for refresh
        begin
            int  n_rf = 0, t_prev = 0, rf_iv = 0, phase = 0;
            logic was_rf = 1'b0;
            reset = 1;
            tick();
            reset = 0;
            cpu_req = 1;
            for (int c = 0; c < 1400 && n_rf < 3; c++) begin
                if (phase == 1) begin
                    mem_ready = 1; phase = 2;
                end else if (phase == 2) begin
                    mem_ready = 0; phase = 0;
                    if (was_rf) check("t6_no_ack", 32'(cpu_ack), 0);
                end else if (mem_req === 1'b1 || mem_rfsh === 1'b1) begin
                    was_rf = mem_rfsh; phase = 1;
                    if (mem_rfsh === 1'b1) begin
                        if (n_rf > 0) rf_iv = c - t_prev;
                        t_prev = c;
                        n_rf++;
                    end
                end
                tick();
            end
            mem_ready = 0; cpu_req = 0;
            check("t6_count", 32'(n_rf >= 2), 1);
            check("t6_interval", 32'(rf_iv >= 543 && rf_iv <= 549), 1);
        end
`else
        check("no_rfsh", 32'(rfsh_seen), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
